// File: rtl/fifo_credit_tx_pkg.sv
// Shared NoC definitions: flit-type encodings, type-field placement, credit limit.
package fifo_credit_tx_pkg;

    // The flit type occupies the top FLIT_TYPE_W bits of each flit.
    localparam int unsigned FLIT_TYPE_W = 2;

    localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY      = 2'b00;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD      = 2'b01;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL      = 2'b10;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD_TAIL = 2'b11;

    localparam int unsigned PKT_CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } frame_state_e;

    // Lowest bit index of the type field for a given flit width.
    function automatic int unsigned flit_type_lsb(input int unsigned data_w);
        return data_w - FLIT_TYPE_W;
    endfunction

    // Usable depth of a one-slot-empty circular FIFO with depth_w address bits.
    function automatic int unsigned max_credits(input int unsigned depth_w);
        return (32'd1 << depth_w) - 32'd1;
    endfunction

endpackage

// File: rtl/fifo_credit_tx_credit.sv
// Downstream credit counter: +1 per returned slot, -1 per issued read, saturating at the maximum.
module credit_counter
    import fifo_credit_tx_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic             sat_err_c_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(max_credits(CNT_W));

    logic [CNT_W-1:0] count_q, count_d;

    // Next count; a return that would exceed the maximum is flagged and dropped.
    always_comb begin
        count_d     = count_q;
        sat_err_c_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == MaxCnt) begin
                sat_err_c_o = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register; reset restores the full credit allowance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= MaxCnt;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fifo_credit_tx.sv
// Credit-based flit transmitter: reads the upstream FIFO while credits remain,
// forwards each flit one cycle later and checks packet framing on the way out.
module fifo_credit_tx
    import fifo_credit_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FIFO_DEPTH_W = 2,
    parameter int unsigned ID           = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    fifo_empty_i,
    input  logic [DATA_W-1:0]       fifo_data_i,
    output logic                    fifo_rd_en_o,
    input  logic                    credit_i,
    output logic                    flit_valid_o,
    output logic [DATA_W-1:0]       flit_data_o,
    output logic [FIFO_DEPTH_W-1:0] credits_o,
    output logic                    pkt_active_o,
    output logic [PKT_CNT_W-1:0]    pkt_cnt_o,
    output logic                    proto_err_o
);

    localparam int unsigned TypeLsb = flit_type_lsb(DATA_W);

    // Elaboration-time sanity check on the flit width; ID tags the offending instance.
    if ((DATA_W < FLIT_TYPE_W) || (ID > 32'h7FFF_FFFF)) begin : g_bad_cfg
        $error("fifo_credit_tx[%0d]: DATA_W must hold the flit type field", ID);
    end

    logic                    rd_en_c;
    logic                    sat_err_c;
    logic [FIFO_DEPTH_W-1:0] credits;
    logic                    flit_valid_q;
    logic [FLIT_TYPE_W-1:0]  flit_type;
    frame_state_e            state_q, state_d;
    logic [PKT_CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic                    proto_err_q, proto_err_d;
    logic                    frame_err;

    // Read strobe: a FIFO entry and a downstream credit must both be available.
    assign rd_en_c = !rst_i && !fifo_empty_i && (credits != '0);

    credit_counter #(
        .CNT_W(FIFO_DEPTH_W)
    ) u_credit (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (credit_i),
        .dec_i      (rd_en_c),
        .sat_err_c_o(sat_err_c),
        .count_o    (credits)
    );

    // Valid follows the read by one cycle, matching the FIFO's registered read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flit_valid_q <= 1'b0;
        end else begin
            flit_valid_q <= rd_en_c;
        end
    end

    assign flit_type = fifo_data_i[TypeLsb +: FLIT_TYPE_W];

    // Framing next-state: only a valid outgoing flit advances the FSM.
    always_comb begin
        state_d   = state_q;
        pkt_cnt_d = pkt_cnt_q;
        frame_err = 1'b0;
        if (flit_valid_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (flit_type == FLIT_HEAD) begin
                        state_d = ST_PKT;
                    end else if (flit_type == FLIT_HEAD_TAIL) begin
                        pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                ST_PKT: begin
                    if (flit_type == FLIT_TAIL) begin
                        state_d   = ST_IDLE;
                        pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
                    end else if (flit_type != FLIT_BODY) begin
                        frame_err = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        proto_err_d = proto_err_q | frame_err | sat_err_c;
    end

    // Framing state, packet counter and sticky error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pkt_cnt_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_cnt_q   <= pkt_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign fifo_rd_en_o = rd_en_c;
    assign flit_valid_o = flit_valid_q;
    assign flit_data_o  = flit_valid_q ? fifo_data_i : '0;
    assign credits_o    = credits;
    assign pkt_active_o = (state_q == ST_PKT);
    assign pkt_cnt_o    = pkt_cnt_q;
    assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_fifo_credit_tx.sv
// Scoreboard bench for fifo_credit_tx: a bench-side FIFO feeds the DUT, issued
// reads push expected flits, valid outputs pop and compare them.
module tb_fifo_credit_tx;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 2;
    localparam int          MAXC = 3;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          fifo_empty_i;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_rd_en_o;
    logic          credit_i;
    logic          flit_valid_o;
    logic [DW-1:0] flit_data_o;
    logic [AW-1:0] credits_o;
    logic          pkt_active_o;
    logic [7:0]    pkt_cnt_o;
    logic          proto_err_o;

    always #5 clk = ~clk;

    fifo_credit_tx #(
        .DATA_W      (DW),
        .FIFO_DEPTH_W(AW),
        .ID          (0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_data_i (fifo_data_i),
        .fifo_rd_en_o(fifo_rd_en_o),
        .credit_i    (credit_i),
        .flit_valid_o(flit_valid_o),
        .flit_data_o (flit_data_o),
        .credits_o   (credits_o),
        .pkt_active_o(pkt_active_o),
        .pkt_cnt_o   (pkt_cnt_o),
        .proto_err_o (proto_err_o)
    );

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] sb_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   m_credits;
    logic m_state;
    int   m_cnt;
    logic m_err;
    int   rd_pulses;
    int   act_cycles;

    // One clock of traffic: drive inputs, check the read strobe, then check outputs after the edge.
    task automatic drive_cycle(input logic cr);
        logic          exp_rd;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_d;
        logic [1:0]    ty;
        d            = 8'hEE;
        exp_d        = '0;
        fifo_empty_i = (src_q.size() == 0);
        credit_i     = cr;
        #1;
        exp_rd = !fifo_empty_i && (m_credits != 0);
        vectors++;
        if (fifo_rd_en_o !== exp_rd) begin
            errors++;
            $display("FAIL rd_en: got %b want %b", fifo_rd_en_o, exp_rd);
        end
        if (fifo_rd_en_o === 1'b1) rd_pulses++;
        if (exp_rd && !cr) begin
            m_credits--;
        end else if (cr && !exp_rd) begin
            if (m_credits == MAXC) m_err = 1'b1;
            else m_credits++;
        end
        if (exp_rd) begin
            d = src_q.pop_front();
            sb_q.push_back(d);
        end
        @(posedge clk);
        #1;
        fifo_data_i = d;
        credit_i    = 1'b0;
        #1;
        vectors++;
        if (credits_o !== 2'(m_credits)) begin
            errors++;
            $display("FAIL credits: got %0d want %0d", credits_o, m_credits);
        end
        vectors++;
        if (flit_valid_o !== exp_rd) begin
            errors++;
            $display("FAIL flit_valid: got %b want %b", flit_valid_o, exp_rd);
        end
        if (exp_rd) exp_d = sb_q.pop_front();
        vectors++;
        if (flit_data_o !== exp_d) begin
            errors++;
            $display("FAIL flit_data: got %h want %h", flit_data_o, exp_d);
        end
        vectors++;
        if ((pkt_active_o !== m_state) || (pkt_cnt_o !== 8'(m_cnt)) || (proto_err_o !== m_err)) begin
            errors++;
            $display("FAIL framing: got act=%b cnt=%0d err=%b want act=%b cnt=%0d err=%b",
                     pkt_active_o, pkt_cnt_o, proto_err_o, m_state, m_cnt, m_err);
        end
        if (pkt_active_o === 1'b1) act_cycles++;
        if (exp_rd) begin
            ty = exp_d[DW-1 -: 2];
            if (!m_state) begin
                if (ty == 2'b01) m_state = 1'b1;
                else if (ty == 2'b11) m_cnt = (m_cnt + 1) % 256;
                else m_err = 1'b1;
            end else begin
                if (ty == 2'b10) begin
                    m_state = 1'b0;
                    m_cnt   = (m_cnt + 1) % 256;
                end else if (ty != 2'b00) begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    // Assert reset away from the edge, check every output at once, then release.
    task automatic reset_and_check();
        rst_i = 1'b1;
        #1;
        vectors++;
        if ((fifo_rd_en_o !== 1'b0) || (flit_valid_o !== 1'b0) || (flit_data_o !== 8'h00)) begin
            errors++;
            $display("FAIL reset_datapath: got rd=%b valid=%b data=%h want 0 0 00",
                     fifo_rd_en_o, flit_valid_o, flit_data_o);
        end
        vectors++;
        if ((credits_o !== 2'd3) || (pkt_active_o !== 1'b0) || (pkt_cnt_o !== 8'd0) || (proto_err_o !== 1'b0)) begin
            errors++;
            $display("FAIL reset_state: got cred=%0d act=%b cnt=%0d err=%b want 3 0 0 0",
                     credits_o, pkt_active_o, pkt_cnt_o, proto_err_o);
        end
        src_q.delete();
        sb_q.delete();
        m_credits = MAXC;
        m_state   = 1'b0;
        m_cnt     = 0;
        m_err     = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ((fifo_rd_en_o !== 1'b0) || (flit_valid_o !== 1'b0)) begin
            errors++;
            $display("FAIL reset_hold: got rd=%b valid=%b want 0 0", fifo_rd_en_o, flit_valid_o);
        end
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset_and_check();
        repeat (2) drive_cycle(1'b0);
    endtask

    // Five queued flits, no credit returns: only three may be read.
    task automatic test_burst();
        src_q = '{8'h41, 8'h05, 8'h06, 8'h07, 8'h88};
        rd_pulses = 0;
        repeat (6) drive_cycle(1'b0);
        vectors++;
        if (rd_pulses != 3) begin
            errors++;
            $display("FAIL burst_reads: got %0d want 3", rd_pulses);
        end
        vectors++;
        if (credits_o !== 2'd0) begin
            errors++;
            $display("FAIL burst_credits: got %0d want 0", credits_o);
        end
    endtask

    // Credit return coinciding with a read keeps the count and the reads flowing.
    task automatic test_simultaneous();
        drive_cycle(1'b1);
        rd_pulses = 0;
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        vectors++;
        if ((rd_pulses != 2) || (credits_o !== 2'd1)) begin
            errors++;
            $display("FAIL simultaneous: got reads=%0d cred=%0d want 2 1", rd_pulses, credits_o);
        end
        repeat (2) drive_cycle(1'b1);
        drive_cycle(1'b0);
    endtask

    task automatic test_legal_packet();
        int start_cnt;
        start_cnt  = m_cnt;
        src_q      = '{8'h41, 8'h05, 8'h86};
        act_cycles = 0;
        repeat (5) drive_cycle(1'b0);
        vectors++;
        if ((act_cycles != 2) || (pkt_cnt_o !== 8'(start_cnt + 1)) || (proto_err_o !== 1'b0)) begin
            errors++;
            $display("FAIL legal_packet: got act=%0d cnt=%0d err=%b want 2 %0d 0",
                     act_cycles, pkt_cnt_o, proto_err_o, start_cnt + 1);
        end
        repeat (3) drive_cycle(1'b1);
    endtask

    task automatic test_overflow();
        drive_cycle(1'b1);
        vectors++;
        if ((credits_o !== 2'd3) || (proto_err_o !== 1'b1)) begin
            errors++;
            $display("FAIL overflow: got cred=%0d err=%b want 3 1", credits_o, proto_err_o);
        end
    endtask

    // BODY while idle is forwarded and flagged; the flag survives later legal packets.
    task automatic test_violation();
        src_q = '{8'h07};
        repeat (3) drive_cycle(1'b0);
        drive_cycle(1'b1);
        src_q = '{8'hC3, 8'h41, 8'h86};
        repeat (5) drive_cycle(1'b0);
        vectors++;
        if ((proto_err_o !== 1'b1) || (pkt_cnt_o !== 8'd2)) begin
            errors++;
            $display("FAIL violation_sticky: got err=%b cnt=%0d want 1 2", proto_err_o, pkt_cnt_o);
        end
        repeat (3) drive_cycle(1'b1);
    endtask

    // Reset lands while PKT is active and the TAIL read is being issued.
    task automatic test_reset_mid_packet();
        src_q = '{8'h41, 8'h05, 8'h86};
        repeat (2) drive_cycle(1'b0);
        fifo_empty_i = 1'b0;
        #1;
        vectors++;
        if ((fifo_rd_en_o !== 1'b1) || (pkt_active_o !== 1'b1)) begin
            errors++;
            $display("FAIL midpkt_pre: got rd=%b act=%b want 1 1", fifo_rd_en_o, pkt_active_o);
        end
        reset_and_check();
        repeat (3) drive_cycle(1'b0);
    endtask

    initial begin
        rst_i        = 1'b1;
        fifo_empty_i = 1'b1;
        fifo_data_i  = '0;
        credit_i     = 1'b0;
        m_credits    = MAXC;
        m_state      = 1'b0;
        m_cnt        = 0;
        m_err        = 1'b0;
        rd_pulses    = 0;
        act_cycles   = 0;
        test_reset();
        test_burst();
        test_simultaneous();
        test_legal_packet();
        test_overflow();
        reset_and_check();
        test_violation();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fifo_credit_tx.md
FIFO_CREDIT_TX -- requirements
Module: fifo_credit_tx

Interface
REQ-001 Parameter DATA_W, default 8, is the flit width in bits; bits [DATA_W-1:DATA_W-2] carry the flit type.
REQ-002 Parameter FIFO_DEPTH_W, default 2, is the downstream FIFO address width; MAX_CREDITS = 2**FIFO_DEPTH_W - 1, the usable depth of a one-slot-empty circular FIFO.
REQ-003 Parameter ID, default 0, is an instance tag used for debug only.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  asynchronous reset, active-high.
REQ-007 fifo_empty_i  input  1  empty flag of the upstream FIFO.
REQ-008 fifo_data_i  input  DATA_W  registered read data of the upstream FIFO, valid one cycle after a read.
REQ-009 fifo_rd_en_o  output  1  read strobe to the upstream FIFO.
REQ-010 credit_i  input  1  one downstream slot freed per high cycle.
REQ-011 flit_valid_o  output  1  flit_data_o carries a flit this cycle.
REQ-012 flit_data_o  output  DATA_W  outgoing flit.
REQ-013 credits_o  output  FIFO_DEPTH_W  current credit count.
REQ-014 pkt_active_o  output  1  high while the framing FSM is in PKT.
REQ-015 pkt_cnt_o  output  8  count of completed packets, wrapping at 255 to 0.
REQ-016 proto_err_o  output  1  sticky error flag.

Function
REQ-017 fifo_rd_en_o SHALL be combinational: high only when fifo_empty_i is 0 and the credit count is nonzero; it SHALL never be high while fifo_empty_i is 1.
REQ-018 flit_valid_o SHALL be the value of fifo_rd_en_o registered by one cycle, giving a latency of exactly 1.
REQ-019 flit_data_o SHALL equal fifo_data_i while flit_valid_o is 1, and SHALL be 0 otherwise.
REQ-020 Credit count per cycle:
- rd_en only: decrement by 1.
- credit_i only: increment by 1.
- both: unchanged.
- neither: unchanged.
REQ-021 credit_i with the count at MAX_CREDITS and no rd_en SHALL hold the count at MAX_CREDITS and set proto_err_o.
REQ-022 Flit type encoding: BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HEAD_TAIL = 2'b11.
REQ-023 The framing FSM has states IDLE and PKT and is evaluated only in cycles where flit_valid_o is 1.
REQ-024 IDLE transitions:
- HEAD -> PKT.
- HEAD_TAIL -> stay IDLE and increment pkt_cnt_o.
- BODY or TAIL -> stay IDLE and set proto_err_o.
REQ-025 PKT transitions:
- BODY -> stay PKT.
- TAIL -> IDLE and increment pkt_cnt_o.
- HEAD or HEAD_TAIL -> stay PKT and set proto_err_o.
REQ-026 Flits that violate framing SHALL still be forwarded unchanged; the block never drops or stalls a flit once it has been read.
REQ-027 proto_err_o SHALL remain 1 until reset once set.

Reset
REQ-028 Asserting rst_i SHALL immediately force:
- credits = MAX_CREDITS
- flit_valid_o = 0, flit_data_o = 0
- FSM = IDLE, pkt_active_o = 0
- pkt_cnt_o = 0, proto_err_o = 0
REQ-029 A flit whose read was issued in the cycle rst_i asserts SHALL be discarded; no flit_valid_o pulse follows reset release.
REQ-030 fifo_rd_en_o SHALL be 0 while rst_i is high.

Structure
REQ-031 A shared NoC package SHALL hold the flit-type localparams (BODY, HEAD, TAIL, HEAD_TAIL), the type-field position, and the MAX_CREDITS formula.
REQ-032 The credit counter SHALL be a sub-module named credit_counter, with inc, dec, a saturation-error output and a count output.
REQ-033 The top level SHALL contain the read-strobe logic, the output register and the framing FSM.

Verification
REQ-034 Burst with no returns: FIFO holds 5 flits, credit_i held 0, DATA_W=8, FIFO_DEPTH_W=2 -> exactly 3 rd_en pulses, 3 valid flits 1 cycle later, credits_o=0, rd_en stays 0.
REQ-035 Simultaneous events: with credits=1, assert credit_i in the same cycle as a read -> credits_o stays 1 and reads continue back-to-back.
REQ-036 Legal packet: send HEAD(0x41), BODY(0x05), TAIL(0x86) -> pkt_active_o high for 2 cycles, pkt_cnt_o 0->1, proto_err_o stays 0.
REQ-037 Framing violation: send BODY(0x07) while IDLE -> flit_data_o=0x07 with valid, proto_err_o=1 and stays 1 across later legal packets.
REQ-038 Credit overflow: with credits=3 and FIFO empty, pulse credit_i -> credits_o=3 and proto_err_o=1.
REQ-039 Reset mid-packet: assert rst_i after HEAD while a read is in flight -> all outputs reach reset values immediately, no valid pulse follows, credits_o=3.
